// File: rtl/dfp_round_pipe_pkg.sv
// Shared rounding-mode type and round-increment decision for the DFP rounding pipeline.
package dfp_round_pipe_pkg;

  typedef enum logic [2:0] {
    RM_CEIL      = 3'd0,
    RM_FLOOR     = 3'd1,
    RM_HALF_UP   = 3'd2,
    RM_HALF_EVEN = 3'd3,
    RM_DOWN      = 3'd4,
    RM_UP        = 3'd5,
    RM_HALF_DOWN = 3'd6,
    RM_RSVD      = 3'd7
  } rm_t;

  // Decide whether the kept digits get +1; lsb is bit 0 of the least significant kept digit.
  function automatic logic round_inc(input rm_t rm, input logic sign, input logic [3:0] r,
                                     input logic sticky, input logic lsb);
    logic nz;
    logic inc;
    nz  = (r != 4'd0) || sticky;
    inc = 1'b0;
    case (rm)
      RM_CEIL:      inc = nz && !sign;
      RM_FLOOR:     inc = nz && sign;
      RM_HALF_UP:   inc = (r >= 4'd5);
      RM_HALF_EVEN: inc = (r > 4'd5) || ((r == 4'd5) && (sticky || lsb));
      RM_DOWN:      inc = 1'b0;
      RM_UP:        inc = nz;
      RM_HALF_DOWN: inc = (r > 4'd5) || ((r == 4'd5) && sticky);
      RM_RSVD:      inc = 1'b0;
      default:      inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/dfp_round_pipe_bcd_inc.sv
// N-digit BCD incrementer with carry-out; combinational.
module dfp_round_pipe_bcd_inc
  import dfp_round_pipe_pkg::*;
#(
  parameter int N = 34
) (
  input  logic [N*4-1:0] sig,
  input  logic           inc,
  output logic [N*4-1:0] sum,
  output logic           co
);

  logic carry;

  // Ripple the decimal carry: a 9 with carry-in wraps to 0 and keeps propagating.
  always_comb begin
    carry = inc;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (carry && (sig[i*4 +: 4] == 4'd9)) begin
        sum[i*4 +: 4] = 4'd0;
      end else begin
        sum[i*4 +: 4] = sig[i*4 +: 4] + {3'b000, carry};
        carry = 1'b0;
      end
    end
    co = carry;
  end

endmodule

// File: rtl/dfp_round_pipe.sv
// Three-stage elastic DFP rounder: decide increment, BCD add, then fix up carry/overflow.
module dfp_round_pipe
  import dfp_round_pipe_pkg::*;
#(
  parameter int N    = 34,
  parameter int EXPW = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           rm,
  input  logic                 in_sign,
  input  logic [EXPW-1:0]      in_exp,
  input  logic [(N+1)*4-1:0]   in_sig,
  input  logic                 in_sticky,
  input  logic                 in_nan,
  input  logic                 in_qnan,
  input  logic                 in_snan,
  input  logic                 in_inf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXPW-1:0]      out_exp,
  output logic [N*4-1:0]       out_sig,
  output logic                 out_nan,
  output logic                 out_qnan,
  output logic                 out_snan,
  output logic                 out_inf,
  output logic                 out_inexact,
  output logic                 out_overflow
);

  localparam int SW = N * 4;
  localparam logic [EXPW-1:0] EXP_MAX = '1;

  logic            v1, sign1, rnd1, inexact1, nan1, qnan1, snan1, inf1;
  logic [EXPW-1:0] exp1;
  logic [SW-1:0]   sig1;
  logic            v2, sign2, co2, inexact2, nan2, qnan2, snan2, inf2;
  logic [EXPW-1:0] exp2;
  logic [SW-1:0]   sig2;
  logic            v3;
  logic            ld1, ld2, ld3;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // An all-ones exponent with no flag raised is an infinity, so it never rounds.
  logic       exp_max_in, special_in, rnd_in, inexact_in, inf_in;
  logic [3:0] r_in;
  assign r_in       = in_sig[3:0];
  assign exp_max_in = (in_exp == EXP_MAX);
  assign inf_in     = in_inf || (exp_max_in && !(in_nan || in_qnan || in_snan));
  assign special_in = in_nan || in_qnan || in_snan || inf_in;
  assign rnd_in     = !special_in && round_inc(rm_t'(rm), in_sign, r_in, in_sticky, in_sig[4]);
  assign inexact_in = !special_in && ((r_in != 4'd0) || in_sticky);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; rnd1 <= 1'b0; inexact1 <= 1'b0;
      nan1 <= 1'b0; qnan1 <= 1'b0; snan1 <= 1'b0; inf1 <= 1'b0;
      exp1 <= '0; sig1 <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        sign1 <= in_sign; rnd1 <= rnd_in; inexact1 <= inexact_in;
        nan1 <= in_nan; qnan1 <= in_qnan; snan1 <= in_snan; inf1 <= inf_in;
        exp1 <= in_exp; sig1 <= in_sig[(N+1)*4-1:4];
      end
    end
  end

  logic [SW-1:0] sum1;
  logic          co1;

  dfp_round_pipe_bcd_inc #(.N(N)) u_inc (
    .sig (sig1),
    .inc (rnd1),
    .sum (sum1),
    .co  (co1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; sign2 <= 1'b0; co2 <= 1'b0; inexact2 <= 1'b0;
      nan2 <= 1'b0; qnan2 <= 1'b0; snan2 <= 1'b0; inf2 <= 1'b0;
      exp2 <= '0; sig2 <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        sign2 <= sign1; co2 <= co1; inexact2 <= inexact1;
        nan2 <= nan1; qnan2 <= qnan1; snan2 <= snan1; inf2 <= inf1;
        exp2 <= exp1; sig2 <= sum1;
      end
    end
  end

  // A carry out of the top digit renormalises to 1000...0 and may push the exponent into infinity.
  logic [EXPW-1:0] exp_inc, exp_res;
  logic [SW-1:0]   sig_res;
  logic            ovf;
  assign exp_inc = exp2 + EXPW'(1);
  assign ovf     = co2 && (exp_inc == EXP_MAX);
  assign exp_res = co2 ? exp_inc : exp2;
  assign sig_res = ovf ? '0 : (co2 ? {4'd1, {(SW-4){1'b0}}} : sig2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; out_sign <= 1'b0; out_exp <= '0; out_sig <= '0;
      out_nan <= 1'b0; out_qnan <= 1'b0; out_snan <= 1'b0; out_inf <= 1'b0;
      out_inexact <= 1'b0; out_overflow <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        out_sign <= sign2; out_exp <= exp_res; out_sig <= sig_res;
        out_nan <= nan2; out_qnan <= qnan2; out_snan <= snan2; out_inf <= inf2 || ovf;
        out_inexact <= inexact2 || ovf; out_overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_dfp_round_pipe.sv
// Directed-vector bench for dfp_round_pipe (N=7): rounding modes, carry, overflow, specials, back-pressure, reset.
module tb_dfp_round_pipe;

  localparam int N    = 7;
  localparam int EXPW = 14;
  localparam int SW   = N * 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid, in_ready;
  logic [2:0]          rm;
  logic                in_sign;
  logic [EXPW-1:0]     in_exp;
  logic [(N+1)*4-1:0]  in_sig;
  logic                in_sticky, in_nan, in_qnan, in_snan, in_inf;
  logic                out_valid, out_ready, out_sign;
  logic [EXPW-1:0]     out_exp;
  logic [SW-1:0]       out_sig;
  logic                out_nan, out_qnan, out_snan, out_inf, out_inexact, out_overflow;

  int checks   = 0;
  int failures = 0;

  dfp_round_pipe #(.N(N), .EXPW(EXPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rm           (rm),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sig       (in_sig),
    .in_sticky    (in_sticky),
    .in_nan       (in_nan),
    .in_qnan      (in_qnan),
    .in_snan      (in_snan),
    .in_inf       (in_inf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_sig      (out_sig),
    .out_nan      (out_nan),
    .out_qnan     (out_qnan),
    .out_snan     (out_snan),
    .out_inf      (out_inf),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      rm;
    logic            sign;
    logic [EXPW-1:0] exp;
    logic [SW-1:0]   kept;
    logic [3:0]      r;
    logic            st;
    logic [3:0]      fl;
    logic [SW-1:0]   e_sig;
    logic [EXPW-1:0] e_exp;
    logic [3:0]      e_fl;
    logic            e_inx;
    logic            e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic addVec(input logic [2:0] vrm, input logic vsign, input logic [EXPW-1:0] vexp,
                        input logic [SW-1:0] vkept, input logic [3:0] vr, input logic vst,
                        input logic [3:0] vfl, input logic [SW-1:0] esig, input logic [EXPW-1:0] eexp,
                        input logic [3:0] efl, input logic einx, input logic eovf);
    vec_t v;
    v.rm = vrm; v.sign = vsign; v.exp = vexp; v.kept = vkept; v.r = vr; v.st = vst; v.fl = vfl;
    v.e_sig = esig; v.e_exp = eexp; v.e_fl = efl; v.e_inx = einx; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int idx, input logic valid);
    in_valid = valid;
    if (valid) begin
      rm        = vecs[idx].rm;
      in_sign   = vecs[idx].sign;
      in_exp    = vecs[idx].exp;
      in_sig    = {vecs[idx].kept, vecs[idx].r};
      in_sticky = vecs[idx].st;
      {in_nan, in_qnan, in_snan, in_inf} = vecs[idx].fl;
    end
  endtask

  task automatic checkResult(input int idx);
    checkOutput($sformatf("txn%0d_sig", idx), out_sig, vecs[idx].e_sig);
    checkOutput($sformatf("txn%0d_exp", idx), out_exp, vecs[idx].e_exp);
    checkOutput($sformatf("txn%0d_flags", idx),
                {out_sign, out_nan, out_qnan, out_snan, out_inf, out_inexact, out_overflow},
                {vecs[idx].sign, vecs[idx].e_fl, vecs[idx].e_inx, vecs[idx].e_ovf});
  endtask

  // Push vecs[first..first+count-1] through the pipe and check results in order.
  task automatic runStream(input int first, input int count, input bit rand_ready);
    int sent, got, inflight, cyc;
    int acc_cyc[64];
    logic acc, del, prev_stall;
    logic [SW-1:0] held_sig;
    sent = 0; got = 0; inflight = 0; cyc = 0; prev_stall = 1'b0; held_sig = '0;
    while (got < count && cyc < 400) begin
      @(negedge clk);
      applyStimulus(first + sent, sent < count);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput("in_ready", in_ready, (inflight < 3) || out_ready);
      if (prev_stall) begin
        checkOutput("hold_valid", out_valid, 1'b1);
        checkOutput("hold_sig", out_sig, held_sig);
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        checkResult(first + got);
        if (!rand_ready) checkOutput($sformatf("txn%0d_latency", first + got), cyc - acc_cyc[got], 3);
      end
      prev_stall = out_valid && !out_ready;
      held_sig   = out_sig;
      if (acc) begin acc_cyc[sent] = cyc; sent++; inflight++; end
      if (del) begin got++; inflight--; end
      cyc++;
    end
    checkOutput("drain_count", got, count);
    @(negedge clk);
    applyStimulus(0, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("idle_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rm = 3'd0; in_sign = 1'b0;
    in_exp = '0; in_sig = '0; in_sticky = 1'b0;
    {in_nan, in_qnan, in_snan, in_inf} = 4'b0000;

    //     rm    s     exp        kept          r     st    fl        e_sig         e_exp      e_fl      inx   ovf
    addVec(3'd3, 1'b0, 14'd100,   28'h1234567,  4'd5, 1'b0, 4'b0000,  28'h1234568,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd3, 1'b0, 14'd100,   28'h1234566,  4'd5, 1'b0, 4'b0000,  28'h1234566,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd2, 1'b0, 14'd100,   28'h9999999,  4'd5, 1'b0, 4'b0000,  28'h1000000,  14'd101,   4'b0000,  1'b1, 1'b0);
    addVec(3'd5, 1'b0, 14'd16382, 28'h9999999,  4'd1, 1'b0, 4'b0000,  28'h0000000,  14'd16383, 4'b0001,  1'b1, 1'b1);
    addVec(3'd0, 1'b1, 14'd100,   28'h1234567,  4'd9, 1'b0, 4'b0000,  28'h1234567,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd1, 1'b1, 14'd100,   28'h1234567,  4'd0, 1'b1, 4'b0000,  28'h1234568,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd2, 1'b0, 14'd16383, 28'h1234567,  4'd9, 1'b0, 4'b0010,  28'h1234567,  14'd16383, 4'b0010,  1'b0, 1'b0);
    addVec(3'd4, 1'b0, 14'd100,   28'h5555555,  4'd9, 1'b1, 4'b0000,  28'h5555555,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd7, 1'b0, 14'd100,   28'h5555555,  4'd9, 1'b1, 4'b0000,  28'h5555555,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd6, 1'b0, 14'd100,   28'h0000001,  4'd5, 1'b0, 4'b0000,  28'h0000001,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd6, 1'b0, 14'd100,   28'h0000001,  4'd5, 1'b1, 4'b0000,  28'h0000002,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd3, 1'b0, 14'd100,   28'h0000008,  4'd6, 1'b0, 4'b0000,  28'h0000009,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd3, 1'b0, 14'd100,   28'h0000009,  4'd5, 1'b1, 4'b0000,  28'h0000010,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd0, 1'b0, 14'd100,   28'h0199999,  4'd0, 1'b1, 4'b0000,  28'h0200000,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd2, 1'b0, 14'd100,   28'h1234567,  4'd4, 1'b1, 4'b0000,  28'h1234567,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd5, 1'b1, 14'd100,   28'h1234567,  4'd0, 1'b0, 4'b0000,  28'h1234567,  14'd100,   4'b0000,  1'b0, 1'b0);
    addVec(3'd5, 1'b0, 14'd16383, 28'h1111111,  4'd9, 1'b0, 4'b0000,  28'h1111111,  14'd16383, 4'b0001,  1'b0, 1'b0);
    addVec(3'd2, 1'b1, 14'd16383, 28'h0000000,  4'd0, 1'b0, 4'b0001,  28'h0000000,  14'd16383, 4'b0001,  1'b0, 1'b0);
    addVec(3'd1, 1'b0, 14'd0,     28'h9999999,  4'd9, 1'b0, 4'b0000,  28'h9999999,  14'd0,     4'b0000,  1'b1, 1'b0);
    addVec(3'd5, 1'b1, 14'd0,     28'h9999999,  4'd1, 1'b0, 4'b0000,  28'h1000000,  14'd1,     4'b0000,  1'b1, 1'b0);
    addVec(3'd3, 1'b0, 14'd200,   28'h2468024,  4'd5, 1'b0, 4'b1100,  28'h2468024,  14'd200,   4'b1100,  1'b0, 1'b0);
    addVec(3'd3, 1'b0, 14'd100,   28'h1234568,  4'd5, 1'b0, 4'b0000,  28'h1234568,  14'd100,   4'b0000,  1'b1, 1'b0);
    addVec(3'd0, 1'b0, 14'd100,   28'h1234567,  4'd0, 1'b0, 4'b0000,  28'h1234567,  14'd100,   4'b0000,  1'b0, 1'b0);

    #12;
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_sig", out_sig, '0);
    checkOutput("reset_exp", out_exp, '0);
    checkOutput("reset_flags", {out_sign, out_nan, out_qnan, out_snan, out_inf, out_inexact, out_overflow}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1'b1);

    runStream(0, vecs.size(), 1'b0);
    runStream(0, vecs.size(), 1'b1);

    // Fill all three stages with the output stalled, then reset mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(i, 1'b1);
    end
    @(negedge clk);
    applyStimulus(0, 1'b0);
    #1;
    checkOutput("full_valid", out_valid, 1'b1);
    checkOutput("full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", out_valid, 1'b0);
    checkOutput("midreset_sig", out_sig, '0);
    checkOutput("midreset_exp", out_exp, '0);
    checkOutput("midreset_flags", {out_sign, out_nan, out_qnan, out_snan, out_inf, out_inexact, out_overflow}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    runStream(3, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
